mod_updown_counter: RTL

MOD_UPDOWN_COUNTER -- requirements
Module: mod_updown_counter

---
 rtl/mod_updown_counter.sv | 101 ++++++++++
 1 files changed

// File: rtl/mod_updown_counter.sv
// Modulo-N up/down counter with parallel load, wrap or saturate at the
// range ends, a one-cycle terminal-count pulse and a sticky overflow flag.
// Count arithmetic is carried one bit wider than the count so that a
// modulus of 2**WIDTH wraps without truncation.
module mod_updown_counter #(
   parameter int WIDTH    = 4,
   parameter int MODULUS  = 16,
   parameter int SATURATE = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             up_dn,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic             at_max,
   output logic             at_min,
   output logic             ovf
);

   // Range limits held at the extended width used for the arithmetic.
   localparam logic [WIDTH:0]   LP_MOD = (WIDTH+1)'(MODULUS);
   localparam logic [WIDTH-1:0] LP_TOP = WIDTH'(MODULUS - 1);

   logic [WIDTH-1:0] r_q;
   logic             r_tc;
   logic             r_ovf;

   logic [WIDTH:0]   w_q_ext;
   logic [WIDTH:0]   w_inc;
   logic [WIDTH:0]   w_dec;
   logic             w_at_top;
   logic             w_at_bot;
   logic             w_bnd;
   logic [WIDTH-1:0] w_ld;
   logic [WIDTH-1:0] w_step;

   assign w_q_ext  = {1'b0, r_q};
   assign w_inc    = w_q_ext + (WIDTH+1)'(1);
   assign w_dec    = w_q_ext - (WIDTH+1)'(1);

   // Incrementing the top value lands exactly on MODULUS; decrementing
   // zero borrows into the extra bit.
   assign w_at_top = (w_inc == LP_MOD);
   assign w_at_bot = w_dec[WIDTH];

   // A boundary step is an enabled step that would leave the range.
   assign w_bnd    = en & (up_dn ? w_at_top : w_at_bot);

   // Out-of-range load values clamp to the top of the range.
   assign w_ld     = ({1'b0, load_val} >= LP_MOD) ? LP_TOP : load_val;

   // Next count for an enabled step: normal +/-1, or wrap / hold at the ends.
   always_comb begin
      w_step = r_q;
      if (up_dn) begin
         if (!w_at_top)
            w_step = w_inc[WIDTH-1:0];
         else if (SATURATE == 0)
            w_step = '0;
         else
            w_step = r_q;
      end else begin
         if (!w_at_bot)
            w_step = w_dec[WIDTH-1:0];
         else if (SATURATE == 0)
            w_step = LP_TOP;
         else
            w_step = r_q;
      end
   end

   // Count, terminal-count pulse and sticky overflow; priority rst > load > en.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_q   <= '0;
         r_tc  <= 1'b0;
         r_ovf <= 1'b0;
      end else if (load) begin
         r_q   <= w_ld;
         r_tc  <= 1'b0;
         r_ovf <= 1'b0;
      end else if (en) begin
         r_q  <= w_step;
         r_tc <= w_bnd;
         if (w_bnd)
            r_ovf <= 1'b1;
      end else begin
         r_tc <= 1'b0;
      end
   end

   assign q      = r_q;
   assign tc     = r_tc;
   assign ovf    = r_ovf;
   assign at_max = w_at_top;
   assign at_min = (r_q == '0);

endmodule
